map_viewport_reader: RTL and testbench

Read-side client of the map RAM. Converts VGA raster coordinates plus a smoothly scrolling camera position into map RAM read addresses, absorbs the RAM's one-cycle synchronous read latency, and delivers a pipeline-aligned 5-bit palette index with a valid flag to the colour mapper. The map is 320x240 map pixels, one RAM word per pixel, row-major. The 640x480 screen shows a 160x120 map-pixel window at 4x scale.

---
 rtl/map_viewport_reader_if.sv | 38 +++
 rtl/map_viewport_reader.sv | 136 +++++++++++++
 tb/tb_map_viewport_reader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/map_viewport_reader_if.sv
// Purpose: raster, camera and map-RAM signals shared by map_viewport_reader and its environment.
// Latency: n/a (signal bundle only).
// Backpressure: none; every signal is sampled or driven once per Clk.
// Ports (master = viewport reader side):
//   DrawX/DrawY       raster column/row in
//   frame_start       once-per-frame pulse in, during vertical blank
//   cam_target_*      requested camera left/top edge in, map pixels
//   cam_snap          jump straight to target on frame_start
//   read_address      map RAM read address out (registered)
//   ram_data          map RAM data in, one cycle after read_address
//   pixel_idx/valid   palette index and active-area flag out
//   cam_x/cam_y       current camera position out
//   moving            camera not yet at the clamped target
interface map_viewport_reader_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        frame_start;
  logic [8:0]  cam_target_x;
  logic [7:0]  cam_target_y;
  logic        cam_snap;
  logic [18:0] read_address;
  logic [4:0]  ram_data;
  logic [4:0]  pixel_idx;
  logic        pixel_valid;
  logic [8:0]  cam_x;
  logic [7:0]  cam_y;
  logic        moving;

  modport master (
    input  DrawX, DrawY, frame_start, cam_target_x, cam_target_y, cam_snap, ram_data,
    output read_address, pixel_idx, pixel_valid, cam_x, cam_y, moving
  );

  modport slave (
    output DrawX, DrawY, frame_start, cam_target_x, cam_target_y, cam_snap, ram_data,
    input  read_address, pixel_idx, pixel_valid, cam_x, cam_y, moving
  );
endinterface

// File: rtl/map_viewport_reader.sv
// Purpose: turn raster position + scrolling camera into map RAM reads and a palette index stream.
// Latency: fixed 3 Clk edges from DrawX/DrawY sample to pixel_idx/pixel_valid.
// Backpressure: none; one raster position accepted every Clk, output never stalls.
// Ports:
//   Clk, Reset  pixel clock; asynchronous active-high reset
//   bus         map_viewport_reader_if.master (raster in, camera control, RAM port, pixel out)
module map_viewport_reader #(
  parameter int MAP_W    = 320,
  parameter int MAP_H    = 240,
  parameter int SCALE_SH = 2,
  parameter int STEP     = 1
) (
  input logic                   Clk,
  input logic                   Reset,
  map_viewport_reader_if.master bus
);

  // Visible window in map pixels (640x480 screen divided by the scale).
  localparam int VIEW_W = 640 >> SCALE_SH;
  localparam int VIEW_H = 480 >> SCALE_SH;

  localparam logic [8:0] MAX_CX = 9'(MAP_W - VIEW_W);
  localparam logic [7:0] MAX_CY = 8'(MAP_H - VIEW_H);
  localparam logic [8:0] STEP_X = 9'(STEP);
  localparam logic [7:0] STEP_Y = 8'(STEP);

  // ---------------------------------------------------------------------------
  // Camera
  // ---------------------------------------------------------------------------
  logic [8:0] tx;
  logic [7:0] ty;
  logic [8:0] cam_x_q, cam_x_nxt;
  logic [7:0] cam_y_q, cam_y_nxt;
  logic       moving_q;

  // Keep the window fully inside the map.
  assign tx = (bus.cam_target_x > MAX_CX) ? MAX_CX : bus.cam_target_x;
  assign ty = (bus.cam_target_y > MAX_CY) ? MAX_CY : bus.cam_target_y;

  // Camera only moves on frame_start so a frame is never drawn with two offsets.
  always_comb begin
    cam_x_nxt = cam_x_q;
    cam_y_nxt = cam_y_q;
    if (bus.frame_start) begin
      if (bus.cam_snap) begin
        cam_x_nxt = tx;
        cam_y_nxt = ty;
      end else begin
        if (tx >= cam_x_q)
          cam_x_nxt = ((tx - cam_x_q) <= STEP_X) ? tx : (cam_x_q + STEP_X);
        else
          cam_x_nxt = ((cam_x_q - tx) <= STEP_X) ? tx : (cam_x_q - STEP_X);

        if (ty >= cam_y_q)
          cam_y_nxt = ((ty - cam_y_q) <= STEP_Y) ? ty : (cam_y_q + STEP_Y);
        else
          cam_y_nxt = ((cam_y_q - ty) <= STEP_Y) ? ty : (cam_y_q - STEP_Y);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cam_x_q  <= '0;
      cam_y_q  <= '0;
      moving_q <= 1'b0;
    end else begin
      cam_x_q  <= cam_x_nxt;
      cam_y_q  <= cam_y_nxt;
      // Compares the pre-update camera, so it settles one edge after a move.
      moving_q <= (cam_x_q != tx) || (cam_y_q != ty);
    end
  end

  // ---------------------------------------------------------------------------
  // Address pipeline
  // Stage 0: sample raster position, add camera offset, decide active.
  // Stage 1: row*320 + column -> read_address.
  // Stage 2: RAM read in flight; active carried alongside.
  // Stage 3: capture ram_data into pixel_idx.
  // ---------------------------------------------------------------------------
  logic [9:0]  dx_sh, dy_sh;
  logic [9:0]  mx_d, my_d;
  logic        active_d;

  logic [9:0]  mx_s0, my_s0;
  logic        act_s0;
  logic [18:0] addr_d;
  logic [18:0] read_address_q;
  logic        act_s1;
  logic        act_s2;
  logic [4:0]  pixel_idx_q;
  logic        pixel_valid_q;

  assign dx_sh    = bus.DrawX >> SCALE_SH;
  assign dy_sh    = bus.DrawY >> SCALE_SH;
  assign active_d = (bus.DrawX < 10'd640) && (bus.DrawY < 10'd480);
  // Within the active area these sums stay at or below 319/239.
  assign mx_d     = {1'b0, cam_x_q} + dx_sh;
  assign my_d     = {2'b0, cam_y_q} + dy_sh;

  // Row stride of 320 as two shifts; address peaks at 76799 so 19 bits never wrap.
  assign addr_d = ({9'd0, my_s0} << 8) + ({9'd0, my_s0} << 6) + {9'd0, mx_s0};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mx_s0          <= '0;
      my_s0          <= '0;
      act_s0         <= 1'b0;
      read_address_q <= '0;
      act_s1         <= 1'b0;
      act_s2         <= 1'b0;
      pixel_idx_q    <= '0;
      pixel_valid_q  <= 1'b0;
    end else begin
      mx_s0          <= mx_d;
      my_s0          <= my_d;
      act_s0         <= active_d;
      // Blanking parks the RAM on address 0 rather than an out-of-map address.
      read_address_q <= act_s0 ? addr_d : '0;
      act_s1         <= act_s0;
      act_s2         <= act_s1;
      // Index is passed through even when blank; valid alone marks it unusable.
      pixel_idx_q    <= bus.ram_data;
      pixel_valid_q  <= act_s2;
    end
  end

  assign bus.read_address = read_address_q;
  assign bus.pixel_idx    = pixel_idx_q;
  assign bus.pixel_valid  = pixel_valid_q;
  assign bus.cam_x        = cam_x_q;
  assign bus.cam_y        = cam_y_q;
  assign bus.moving       = moving_q;

endmodule

// File: tb/tb_map_viewport_reader.sv
module tb_map_viewport_reader;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int tests = 0;
  int fails = 0;

  logic [4:0] mem [0:76799];

  always #5 Clk = ~Clk;

  map_viewport_reader_if bus ();

  map_viewport_reader dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Synchronous-read map RAM: data one cycle after the address.
  always @(posedge Clk) bus.ram_data <= mem[bus.read_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    logic [9:0] xs [0:12];

    for (int i = 0; i < 76800; i++) mem[i] = 5'(i % 31);
    mem[0]     = 5'd7;
    mem[321]   = 5'd19;
    mem[76799] = 5'd25;

    bus.DrawX = 10'd700;
    bus.DrawY = 10'd0;
    bus.frame_start = 1'b0;
    bus.cam_target_x = 9'd0;
    bus.cam_target_y = 8'd0;
    bus.cam_snap = 1'b0;
    bus.ram_data = 5'd0;

    // Reset state, checked before any clock edge.
    #1 Reset = 1'b1;
    #1;
    check("rst_addr",   32'(bus.read_address), 32'd0);
    check("rst_idx",    32'(bus.pixel_idx),    32'd0);
    check("rst_valid",  32'(bus.pixel_valid),  32'd0);
    check("rst_cam_x",  32'(bus.cam_x),        32'd0);
    check("rst_cam_y",  32'(bus.cam_y),        32'd0);
    check("rst_moving", 32'(bus.moving),       32'd0);
    tick();
    tick();

    // Single active sample at (4,4) -> map (1,1) -> address 321.
    Reset = 1'b0;
    bus.DrawX = 10'd4;
    bus.DrawY = 10'd4;
    tick();                               // edge n samples
    bus.DrawX = 10'd700;
    check("lat_addr_n",  32'(bus.read_address), 32'd0);
    tick();                               // n+1
    check("lat_addr_n1", 32'(bus.read_address), 32'd321);
    tick();                               // n+2
    check("lat_valid_n2", 32'(bus.pixel_valid), 32'd0);
    check("lat_addr_n2",  32'(bus.read_address), 32'd0);
    tick();                               // n+3
    check("lat_idx_n3",   32'(bus.pixel_idx),   32'd19);
    check("lat_valid_n3", 32'(bus.pixel_valid), 32'd1);
    tick();                               // n+4: blank, address 0 content
    check("lat_valid_n4", 32'(bus.pixel_valid), 32'd0);
    check("lat_idx_n4",   32'(bus.pixel_idx),   32'd7);

    // Snap with clamping: (200,200) -> (160,120).
    bus.cam_target_x = 9'd200;
    bus.cam_target_y = 8'd200;
    bus.cam_snap = 1'b1;
    frame_pulse();
    bus.cam_snap = 1'b0;
    check("snap_cam_x",  32'(bus.cam_x),  32'd160);
    check("snap_cam_y",  32'(bus.cam_y),  32'd120);
    check("snap_moving_pre", 32'(bus.moving), 32'd1);
    tick();
    check("snap_moving", 32'(bus.moving), 32'd0);
    bus.DrawX = 10'd639;
    bus.DrawY = 10'd479;
    tick();
    bus.DrawX = 10'd700;
    tick();
    check("max_addr", 32'(bus.read_address), 32'd76799);
    tick();
    tick();
    check("max_idx",   32'(bus.pixel_idx),   32'd25);
    check("max_valid", 32'(bus.pixel_valid), 32'd1);

    // Stepping toward (3,0) one map pixel per frame.
    bus.cam_target_x = 9'd0;
    bus.cam_target_y = 8'd0;
    bus.cam_snap = 1'b1;
    frame_pulse();
    bus.cam_snap = 1'b0;
    check("home_cam_x", 32'(bus.cam_x), 32'd0);
    check("home_cam_y", 32'(bus.cam_y), 32'd0);
    bus.cam_target_x = 9'd3;
    frame_pulse();
    check("step1_cam_x", 32'(bus.cam_x), 32'd1);
    tick();
    tick();
    check("hold_cam_x",  32'(bus.cam_x),  32'd1);
    check("hold_moving", 32'(bus.moving), 32'd1);
    frame_pulse();
    check("step2_cam_x", 32'(bus.cam_x), 32'd2);
    frame_pulse();
    check("step3_cam_x",  32'(bus.cam_x),  32'd3);
    check("step3_moving", 32'(bus.moving), 32'd1);
    tick();
    check("arrived_moving", 32'(bus.moving), 32'd0);
    check("arrived_cam_y",  32'(bus.cam_y),  32'd0);

    // Raster sweep across the right edge of the active area, camera (3,0).
    bus.DrawY = 10'd0;
    for (int i = 0; i < 13; i++) begin
      xs[i] = 10'(632 + i);
      bus.DrawX = xs[i];
      tick();
      if (i >= 1)
        check($sformatf("sweep_addr_%0d", i), 32'(bus.read_address),
              (xs[i-1] < 10'd640) ? 32'(3 + (xs[i-1] >> 2)) : 32'd0);
      if (i >= 3)
        check($sformatf("sweep_valid_%0d", i), 32'(bus.pixel_valid),
              (xs[i-3] < 10'd640) ? 32'd1 : 32'd0);
    end

    // Vertical blanking row.
    bus.DrawX = 10'd10;
    bus.DrawY = 10'd0;
    tick();
    tick();
    tick();
    bus.DrawY = 10'd480;
    tick();                               // n
    tick();                               // n+1
    check("vblank_addr", 32'(bus.read_address), 32'd0);
    tick();                               // n+2
    check("vblank_valid_n2", 32'(bus.pixel_valid), 32'd1);
    tick();                               // n+3
    check("vblank_valid_n3", 32'(bus.pixel_valid), 32'd0);

    // Scroll back from (10,0) toward 0.
    bus.cam_target_x = 9'd10;
    bus.cam_snap = 1'b1;
    frame_pulse();
    bus.cam_snap = 1'b0;
    bus.cam_target_x = 9'd0;
    check("dec_start", 32'(bus.cam_x), 32'd10);
    frame_pulse();
    check("dec1_cam_x", 32'(bus.cam_x), 32'd9);
    tick();
    check("dec_hold", 32'(bus.cam_x), 32'd9);
    frame_pulse();
    check("dec2_cam_x", 32'(bus.cam_x), 32'd8);

    // Mid-scan reset: cam (8,0), raster (20,8) -> map (13,2) -> 653.
    bus.DrawX = 10'd20;
    bus.DrawY = 10'd8;
    tick();
    tick();
    tick();
    tick();
    check("scan_addr",  32'(bus.read_address), 32'd653);
    check("scan_valid", 32'(bus.pixel_valid),  32'd1);
    check("scan_moving", 32'(bus.moving),      32'd1);
    #2 Reset = 1'b1;
    #1;
    check("arst_cam_x",  32'(bus.cam_x),        32'd0);
    check("arst_valid",  32'(bus.pixel_valid),  32'd0);
    check("arst_addr",   32'(bus.read_address), 32'd0);
    check("arst_idx",    32'(bus.pixel_idx),    32'd0);
    check("arst_moving", 32'(bus.moving),       32'd0);
    tick();
    Reset = 1'b0;
    bus.DrawX = 10'd700;
    frame_pulse();
    check("post_rst_cam_x", 32'(bus.cam_x), 32'd0);
    tick();
    check("post_rst_moving", 32'(bus.moving), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
